// File: rtl/display_bcd_seq_if.sv
// Bus between the memory-mapped display register (master) and display_bcd_seq (slave).
// Carries the conversion request, status pulses and the active-low segment pins.
interface display_bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic [WIDTH-1:0]          din;
    logic                      load;
    logic                      busy;
    logic                      done;
    logic [(DIGITS+1)*8-1:0]   seg;
    logic                      dot;

    modport master (
        output din, load,
        input  busy, done, seg, dot
    );

    modport slave (
        input  din, load,
        output busy, done, seg, dot
    );
endinterface

// File: rtl/display_bcd_seq.sv
// Sequential signed/unsigned decimal 7-segment driver using a one-bit-per-clock double-dabble converter.
// Define DISPLAY_BCD_SEQ_LZB_EN to blank leading zero digits (digit 0 and the sign digit keep their positions).
module display_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input logic              clk,
    input logic              rst,
    display_bcd_seq_if.slave bus
);
    localparam int BCDW       = 4 * DIGITS;
    localparam int SEGW       = 8 * (DIGITS + 1);
    localparam int CNTW       = $clog2(WIDTH + 1);
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    generate
        if (WIDTH < 4) begin : gWidthCheck
            $error("display_bcd_seq: WIDTH must be at least 4");
        end
        if (DIGITS < MIN_DIGITS) begin : gDigitsCheck
            $error("display_bcd_seq: DIGITS too small to hold a WIDTH-bit magnitude");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BCDW-1:0]   bcd_q, bcd_d;
    logic [BCDW-1:0]   adjBcd;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              signNew;
    logic [SEGW-1:0]   seg_q, seg_d;
    logic [SEGW-1:0]   segEnc;
    logic              done_q, done_d;
`ifdef DISPLAY_BCD_SEQ_LZB_EN
    logic              seenNz;
`endif

    function automatic logic [7:0] encDigit(input logic [3:0] n);
        case (n)
            4'd0:    encDigit = 8'hC0;
            4'd1:    encDigit = 8'hF9;
            4'd2:    encDigit = 8'hA4;
            4'd3:    encDigit = 8'hB0;
            4'd4:    encDigit = 8'h99;
            4'd5:    encDigit = 8'h92;
            4'd6:    encDigit = 8'h82;
            4'd7:    encDigit = 8'hF8;
            4'd8:    encDigit = 8'h80;
            4'd9:    encDigit = 8'h98;
            default: encDigit = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            seg_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    // Negative inputs are converted as their magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        signNew = (SIGNED != 0) && bus.din[WIDTH-1];
        adjBcd  = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adjBcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = SHIFT;
                    sign_d  = signNew;
                    bin_d   = signNew ? (~bus.din + WIDTH'(1)) : bus.din;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adjBcd[BCDW-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                seg_d   = segEnc;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan runs from the top so leading-zero blanking can track the first nonzero digit.
    always_comb begin
        segEnc = '1;
`ifdef DISPLAY_BCD_SEQ_LZB_EN
        seenNz = 1'b0;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef DISPLAY_BCD_SEQ_LZB_EN
            if (bcd_q[4*i +: 4] != 4'd0) begin
                seenNz = 1'b1;
            end
            if (seenNz || (i == 0)) begin
                segEnc[8*i +: 8] = encDigit(bcd_q[4*i +: 4]);
            end
`else
            segEnc[8*i +: 8] = encDigit(bcd_q[4*i +: 4]);
`endif
        end
        segEnc[8*DIGITS +: 8] = sign_q ? 8'hBF : 8'hFF;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.seg  = seg_q;
    assign bus.dot  = 1'b1;
endmodule
